// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between cache (req 0) and TLB walker (req 1).
// Optional BUSY watchdog enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be within 2..255");
    end

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                last_q, last_d;
    logic                win;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
`endif

    // On a tie the requester that did not win last time gets the port.
    assign win = (req == 2'b11) ? ~last_q : req[1];

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        rdata_d   = rdata_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        last_d    = last_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d     = win ? 2'b10 : 2'b01;
                    m_req_d   = 1'b1;
                    m_we_d    = win ? we[1] : we[0];
                    m_addr_d  = win ? addr1 : addr0;
                    m_wdata_d = win ? wdata1 : wdata0;
                    last_d    = win;
                    state_d   = BUSY;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end
            end

            BUSY: begin
                // Completion wins over a watchdog expiry on the same edge.
                if (m_done) begin
                    rdata_d = m_we_q ? '0 : m_rdata;
                    m_req_d = 1'b0;
                    done_d  = gnt_q;
                    state_d = RESP;
                end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d = '0;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end

            RESP: begin
                gnt_d   = 2'b00;
                done_d  = 2'b00;
                state_d = IDLE;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            last_q    <= 1'b1;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            last_q    <= last_d;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
